spgd_seq_ctrl: RTL and testbench

Iteration sequencer for the SPGD datapath (perturbation registers, J+/J- capture registers, U update registers, DAC mux, PRNG). It steps through perturb -> apply U+dU -> settle -> ADC capture J+ -> apply U-dU -> settle -> ADC capture J- -> arithmetic settle -> commit U. It also provides an iteration counter, an iteration limit and status for the GPIO readback bank. It drives the existing register write strobes, RNG_CLK and DAC_SEL.

---
 rtl/spgd_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_spgd_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spgd_seq_ctrl.sv
// SPGD iteration sequencer: perturb, measure J+ and J-, settle arithmetic, commit U.
// Define SPGD_ADC_TIMEOUT_EN to enable the ADC_DONE watchdog and the ERR state.
module spgd_seq_ctrl #(
  parameter int CNT_WIDTH   = 16,
  parameter int CALC_CYC    = 4,
  parameter int ITER_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  ADC_CLK,
  input  logic                  RST_N,
  input  logic                  SYS_EN,
  input  logic [CNT_WIDTH-1:0]  SETTLE_IN,
  input  logic [ITER_WIDTH-1:0] ITER_MAX,
  input  logic                  ADC_DONE,
  output logic                  ADC_EN,
  output logic                  RNG_CLK,
  output logic                  DELTA_U_WRT,
  output logic                  J_P_WRT,
  output logic                  J_M_WRT,
  output logic                  U_WRT,
  output logic [1:0]            DAC_SEL,
  output logic [3:0]            FSM_STATE,
  output logic [ITER_WIDTH-1:0] ITER_CNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  TIMEOUT_ERR
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  PERT   = 4'd1,  RNG    = 4'd2,  SET_P  = 4'd3,
    ADC_P  = 4'd4,  WAIT_P = 4'd5,  SET_M  = 4'd6,  ADC_M  = 4'd7,
    WAIT_M = 4'd8,  CALC   = 4'd9,  UPDATE = 4'd10, DONE_S = 4'd11,
    ERR    = 4'd12
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CALC_LOAD = CNT_WIDTH'(CALC_CYC);

  state_t                state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [ITER_WIDTH-1:0] iter_cnt_reg, iter_cnt_next;
  logic [CNT_WIDTH-1:0]  settle_load;
  logic                  wd_expired;

  logic rng_clk_reg, rng_clk_next;
  logic delta_u_wrt_reg, delta_u_wrt_next;
  logic adc_en_reg, adc_en_next;
  logic j_p_wrt_reg, j_p_wrt_next;
  logic j_m_wrt_reg, j_m_wrt_next;
  logic u_wrt_reg, u_wrt_next;
  logic [1:0] dac_sel_reg, dac_sel_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

  // A zero settle request still gives the DAC one cycle.
  assign settle_load = (SETTLE_IN == '0) ? CNT_WIDTH'(1) : SETTLE_IN;

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      iter_cnt_reg    <= '0;
      rng_clk_reg     <= 1'b0;
      delta_u_wrt_reg <= 1'b0;
      adc_en_reg      <= 1'b0;
      j_p_wrt_reg     <= 1'b0;
      j_m_wrt_reg     <= 1'b0;
      u_wrt_reg       <= 1'b0;
      dac_sel_reg     <= 2'b00;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      iter_cnt_reg    <= iter_cnt_next;
      rng_clk_reg     <= rng_clk_next;
      delta_u_wrt_reg <= delta_u_wrt_next;
      adc_en_reg      <= adc_en_next;
      j_p_wrt_reg     <= j_p_wrt_next;
      j_m_wrt_reg     <= j_m_wrt_next;
      u_wrt_reg       <= u_wrt_next;
      dac_sel_reg     <= dac_sel_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (SYS_EN) state_next = PERT;
      PERT:   state_next = RNG;
      RNG:    state_next = SET_P;
      SET_P:  if (cnt_reg <= CNT_WIDTH'(1)) state_next = ADC_P;
      ADC_P:  state_next = WAIT_P;
      WAIT_P: begin
        if (ADC_DONE)        state_next = SET_M;
        else if (wd_expired) state_next = ERR;
      end
      SET_M:  if (cnt_reg <= CNT_WIDTH'(1)) state_next = ADC_M;
      ADC_M:  state_next = WAIT_M;
      WAIT_M: begin
        if (ADC_DONE)        state_next = CALC;
        else if (wd_expired) state_next = ERR;
      end
      CALC:   if (cnt_reg <= CNT_WIDTH'(1)) state_next = UPDATE;
      UPDATE: begin
        // iter_cnt_reg already holds the incremented count here
        if (ITER_MAX != '0 && iter_cnt_reg == ITER_MAX) state_next = DONE_S;
        else if (SYS_EN)                                state_next = PERT;
        else                                            state_next = IDLE;
      end
      DONE_S: if (!SYS_EN) state_next = IDLE;
      ERR:    if (!SYS_EN) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    cnt_next = cnt_reg;
    if (state_reg == RNG || (state_reg == WAIT_P && state_next == SET_M))
      cnt_next = settle_load;
    else if (state_reg == WAIT_M && state_next == CALC)
      cnt_next = CALC_LOAD;
    else if (cnt_reg != '0)
      cnt_next = cnt_reg - CNT_WIDTH'(1);

    iter_cnt_next = iter_cnt_reg;
    if (state_reg == CALC && state_next == UPDATE)
      iter_cnt_next = iter_cnt_reg + ITER_WIDTH'(1);
  end

  // Outputs are decoded from the upcoming state so the registered copies line up with FSM_STATE.
  always_comb begin
    rng_clk_next     = (state_next == PERT);
    delta_u_wrt_next = (state_next == RNG);
    adc_en_next      = (state_next == ADC_P) || (state_next == ADC_M);
    j_p_wrt_next     = (state_reg == WAIT_P) && (state_next == SET_M);
    j_m_wrt_next     = (state_reg == WAIT_M) && (state_next == CALC);
    u_wrt_next       = (state_next == UPDATE);
    busy_next        = !((state_next == IDLE) || (state_next == DONE_S));
    done_next        = (state_next == DONE_S);
    case (state_next)
      SET_P, ADC_P, WAIT_P:       dac_sel_next = 2'b01;
      SET_M, ADC_M, WAIT_M, CALC: dac_sel_next = 2'b10;
      default:                    dac_sel_next = 2'b00;
    endcase
  end

`ifdef SPGD_ADC_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYC) + 1;

  logic [WD_WIDTH-1:0] wd_reg;
  logic                timeout_err_reg;

  assign wd_expired = (wd_reg >= WD_WIDTH'(TIMEOUT_CYC - 1));

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_reg          <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if ((state_next == WAIT_P || state_next == WAIT_M) && state_next != state_reg)
        wd_reg <= '0;
      else if (state_reg == WAIT_P || state_reg == WAIT_M)
        wd_reg <= wd_reg + WD_WIDTH'(1);
      if (state_next == ERR)
        timeout_err_reg <= 1'b1;
    end
  end

  assign TIMEOUT_ERR = timeout_err_reg;
`else
  // Without the watchdog the WAIT states never expire; TIMEOUT_CYC has no effect.
  assign wd_expired  = (TIMEOUT_CYC < 0);
  assign TIMEOUT_ERR = 1'b0;
`endif

  assign RNG_CLK     = rng_clk_reg;
  assign DELTA_U_WRT = delta_u_wrt_reg;
  assign ADC_EN      = adc_en_reg;
  assign J_P_WRT     = j_p_wrt_reg;
  assign J_M_WRT     = j_m_wrt_reg;
  assign U_WRT       = u_wrt_reg;
  assign DAC_SEL     = dac_sel_reg;
  assign FSM_STATE   = state_reg;
  assign ITER_CNT    = iter_cnt_reg;
  assign BUSY        = busy_reg;
  assign DONE        = done_reg;

endmodule

// File: tb/tb_spgd_seq_ctrl.sv
// Directed bench for spgd_seq_ctrl; traces each cycle and checks sequencing against hand-derived indices.
module tb_spgd_seq_ctrl;

  logic        ADC_CLK = 1'b0;
  logic        RST_N;
  logic        SYS_EN;
  logic [15:0] SETTLE_IN;
  logic [31:0] ITER_MAX;
  logic        ADC_DONE;
  logic        ADC_EN, RNG_CLK, DELTA_U_WRT, J_P_WRT, J_M_WRT, U_WRT;
  logic [1:0]  DAC_SEL;
  logic [3:0]  FSM_STATE;
  logic [31:0] ITER_CNT;
  logic        BUSY, DONE, TIMEOUT_ERR;

  spgd_seq_ctrl #(
    .CNT_WIDTH(16), .CALC_CYC(4), .ITER_WIDTH(32), .TIMEOUT_CYC(1024)
  ) dut (
    .ADC_CLK(ADC_CLK), .RST_N(RST_N), .SYS_EN(SYS_EN), .SETTLE_IN(SETTLE_IN),
    .ITER_MAX(ITER_MAX), .ADC_DONE(ADC_DONE), .ADC_EN(ADC_EN), .RNG_CLK(RNG_CLK),
    .DELTA_U_WRT(DELTA_U_WRT), .J_P_WRT(J_P_WRT), .J_M_WRT(J_M_WRT), .U_WRT(U_WRT),
    .DAC_SEL(DAC_SEL), .FSM_STATE(FSM_STATE), .ITER_CNT(ITER_CNT), .BUSY(BUSY),
    .DONE(DONE), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  localparam int TR = 1200;
  // strobe codes: 1 RNG_CLK, 2 DELTA_U_WRT, 3 ADC_EN, 4 J_P_WRT, 5 J_M_WRT, 6 U_WRT, 7 several at once
  logic [3:0]  st_tr   [TR];
  logic [1:0]  dac_tr  [TR];
  logic [2:0]  sb_tr   [TR];
  logic [31:0] it_tr   [TR];
  logic        busy_tr [TR];
  logic        done_tr [TR];
  logic        terr_tr [TR];

  int n;
  int since_en;
  bit auto_done;
  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge, log, then drive the ADC responder.
  task automatic cyc();
    int k;
    logic [2:0] c;
    @(negedge ADC_CLK);
    k = int'(RNG_CLK) + int'(DELTA_U_WRT) + int'(ADC_EN) + int'(J_P_WRT) + int'(J_M_WRT) + int'(U_WRT);
    if (k > 1)            c = 3'd7;
    else if (RNG_CLK)     c = 3'd1;
    else if (DELTA_U_WRT) c = 3'd2;
    else if (ADC_EN)      c = 3'd3;
    else if (J_P_WRT)     c = 3'd4;
    else if (J_M_WRT)     c = 3'd5;
    else if (U_WRT)       c = 3'd6;
    else                  c = 3'd0;
    if (n < TR) begin
      st_tr[n]   = FSM_STATE;
      dac_tr[n]  = DAC_SEL;
      sb_tr[n]   = c;
      it_tr[n]   = ITER_CNT;
      busy_tr[n] = BUSY;
      done_tr[n] = DONE;
      terr_tr[n] = TIMEOUT_ERR;
    end
    if (c != 3'd0)
      $display("cyc=%0d state=%0d strobe=%0d dac=%0d iter=%0d", n, FSM_STATE, c, DAC_SEL, ITER_CNT);
    n++;
    // ADC_DONE is high for the whole second clock after ADC_EN.
    if (ADC_EN) since_en = 0;
    else if (since_en >= 0 && since_en < 1000000) since_en++;
    ADC_DONE = auto_done && (since_en == 2);
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  function automatic logic [31:0] strobe_seq(input int lo, input int hi);
    logic [31:0] s = '0;
    for (int i = lo; i <= hi; i++)
      if (sb_tr[i] != 3'd0) s = (s << 4) | {29'd0, sb_tr[i]};
    return s;
  endfunction

  function automatic int count_code(input int lo, input int hi, input logic [2:0] code);
    int cnt = 0;
    for (int i = lo; i <= hi; i++)
      if (sb_tr[i] == code) cnt++;
    return cnt;
  endfunction

  function automatic int count_any(input int lo, input int hi);
    int cnt = 0;
    for (int i = lo; i <= hi; i++)
      if (sb_tr[i] != 3'd0) cnt++;
    return cnt;
  endfunction

  function automatic int first_code(input int lo, input int hi, input logic [2:0] code);
    for (int i = lo; i <= hi; i++)
      if (sb_tr[i] == code) return i;
    return -1;
  endfunction

  initial begin
    total = 0; bad = 0; n = 0; since_en = -1; auto_done = 1'b1;
    RST_N = 1'b0; SYS_EN = 1'b0; ADC_DONE = 1'b0; SETTLE_IN = 16'd3; ITER_MAX = 32'd0;

    // Reset state
    run(2);
    chk("rst_state", {28'd0, FSM_STATE}, 32'd0);
    chk("rst_strobes", {26'd0, RNG_CLK, DELTA_U_WRT, ADC_EN, J_P_WRT, J_M_WRT, U_WRT}, 32'd0);
    chk("rst_dac", {30'd0, DAC_SEL}, 32'd0);
    chk("rst_iter", ITER_CNT, 32'd0);
    chk("rst_flags", {29'd0, BUSY, DONE, TIMEOUT_ERR}, 32'd0);
    RST_N = 1'b1;
    run(2);
    chk("idle_hold", {28'd0, FSM_STATE}, 32'd0);

    // Nominal: SETTLE_IN=3, two free-running iterations of 19 cycles
    SYS_EN = 1'b1; n = 0;
    run(38);
    chk("nom_pert0", {28'd0, st_tr[0]}, 32'd1);
    chk("nom_seq", strobe_seq(0, 18), 32'h01234356);
    chk("nom_first_adc", first_code(0, 18, 3'd3), 32'd5);
    chk("nom_dac_rng", {30'd0, dac_tr[1]}, 32'd0);
    chk("nom_dac_setp_a", {30'd0, dac_tr[2]}, 32'd1);
    chk("nom_dac_setp_b", {30'd0, dac_tr[4]}, 32'd1);
    chk("nom_setm", {28'd0, st_tr[8]}, 32'd6);
    chk("nom_calc", {28'd0, st_tr[14]}, 32'd9);
    chk("nom_dac_calc", {30'd0, dac_tr[17]}, 32'd2);
    chk("nom_update", {28'd0, st_tr[18]}, 32'd10);
    chk("nom_iter_pre", it_tr[17], 32'd0);
    chk("nom_iter_upd", it_tr[18], 32'd1);
    chk("nom_len19", {28'd0, st_tr[19]}, 32'd1);
    chk("nom_iter2", it_tr[37], 32'd2);
    chk("nom_exclusive", count_code(0, 37, 3'd7), 32'd0);
    SYS_EN = 1'b0;
    run(1);
    chk("nom_stop_state", {28'd0, st_tr[38]}, 32'd0);
    chk("nom_stop_dac", {30'd0, dac_tr[38]}, 32'd0);
    chk("nom_stop_iter", it_tr[38], 32'd2);

    // SETTLE_IN=0: settle states last exactly one cycle
    SETTLE_IN = 16'd0; SYS_EN = 1'b1; n = 0;
    run(15);
    SYS_EN = 1'b0;
    run(1);
    chk("s0_setp", {28'd0, st_tr[2]}, 32'd3);
    chk("s0_adcp", {28'd0, st_tr[3]}, 32'd4);
    chk("s0_setm", {28'd0, st_tr[6]}, 32'd6);
    chk("s0_adcm", {28'd0, st_tr[7]}, 32'd7);
    chk("s0_update", {28'd0, st_tr[14]}, 32'd10);
    chk("s0_idle", {28'd0, st_tr[15]}, 32'd0);
    chk("s0_iter", it_tr[15], 32'd3);

    // SYS_EN dropped in WAIT_P: iteration still completes once
    SETTLE_IN = 16'd3; SYS_EN = 1'b1; n = 0;
    run(7);
    chk("drop_waitp", {28'd0, st_tr[6]}, 32'd5);
    SYS_EN = 1'b0;
    run(15);
    chk("drop_uwrt", count_code(0, 21, 3'd6), 32'd1);
    chk("drop_rngclk", count_code(0, 21, 3'd1), 32'd1);
    chk("drop_update", {28'd0, st_tr[18]}, 32'd10);
    chk("drop_idle", {28'd0, st_tr[19]}, 32'd0);
    chk("drop_dac", {30'd0, dac_tr[19]}, 32'd0);
    chk("drop_iter", it_tr[21], 32'd4);

    // Reset asserted in SET_P takes effect without a clock edge
    SYS_EN = 1'b1; n = 0;
    run(4);
    chk("rstmid_setp", {28'd0, st_tr[3]}, 32'd3);
    RST_N = 1'b0;
    #1;
    chk("rstmid_state", {28'd0, FSM_STATE}, 32'd0);
    chk("rstmid_iter", ITER_CNT, 32'd0);
    chk("rstmid_dac", {30'd0, DAC_SEL}, 32'd0);
    chk("rstmid_busy", {31'd0, BUSY}, 32'd0);
    run(1);
    SYS_EN = 1'b0; RST_N = 1'b1;
    run(1);

    // ITER_MAX=5 with SETTLE_IN=0 (15-cycle iterations)
    SETTLE_IN = 16'd0; ITER_MAX = 32'd5; SYS_EN = 1'b1; n = 0;
    run(80);
    chk("max_update5", {28'd0, st_tr[74]}, 32'd10);
    chk("max_iter5", it_tr[74], 32'd5);
    chk("max_done_pre", {31'd0, done_tr[74]}, 32'd0);
    chk("max_done_state", {28'd0, st_tr[75]}, 32'd11);
    chk("max_done_flag", {31'd0, done_tr[75]}, 32'd1);
    chk("max_busy", {31'd0, busy_tr[75]}, 32'd0);
    chk("max_quiet", count_any(75, 79), 32'd0);
    chk("max_hold", {28'd0, st_tr[79]}, 32'd11);
    chk("max_uwrt", count_code(0, 79, 3'd6), 32'd5);
    SYS_EN = 1'b0;
    run(1);
    chk("max_idle", {28'd0, st_tr[80]}, 32'd0);
    chk("max_iter_kept", it_tr[80], 32'd5);
    chk("max_done_clr", {31'd0, done_tr[80]}, 32'd0);

    // ADC_DONE never arrives
    auto_done = 1'b0; ADC_DONE = 1'b0; ITER_MAX = 32'd0; SYS_EN = 1'b1; n = 0;
`ifdef SPGD_ADC_TIMEOUT_EN
    run(1030);
    chk("to_waitp", {28'd0, st_tr[4]}, 32'd5);
    chk("to_last_wait", {28'd0, st_tr[1027]}, 32'd5);
    chk("to_err", {28'd0, st_tr[1028]}, 32'd12);
    chk("to_flag_pre", {31'd0, terr_tr[1027]}, 32'd0);
    chk("to_flag", {31'd0, terr_tr[1028]}, 32'd1);
    chk("to_dac", {30'd0, dac_tr[1028]}, 32'd0);
    chk("to_no_jp", count_code(0, 1029, 3'd4), 32'd0);
    chk("to_no_u", count_code(0, 1029, 3'd6), 32'd0);
    SYS_EN = 1'b0;
    run(2);
    chk("to_idle", {28'd0, st_tr[1031]}, 32'd0);
    chk("to_sticky", {31'd0, terr_tr[1031]}, 32'd1);
`else
    run(1100);
    chk("wait_waitp", {28'd0, st_tr[4]}, 32'd5);
    chk("wait_stuck", {28'd0, st_tr[1099]}, 32'd5);
    chk("wait_dac", {30'd0, dac_tr[1099]}, 32'd1);
    chk("wait_no_jp", count_code(0, 1099, 3'd4), 32'd0);
    chk("wait_no_flag", {31'd0, terr_tr[1099]}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
